// File: rtl/color_pkg.sv
// ============================================================================
//  Module      : color_pkg
//  Description : Shared types and constants for the colour classifier slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_pkg;

    // Default bits per colour channel
    localparam int CH_W_DEFAULT = 8;

    // Channel positions inside a packed {r,g,b} word
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // Persistence filter states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Index used to report "no class hit"
    function automatic int none_idx(input int num_classes);
        return num_classes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/color_range_check.sv
// ============================================================================
//  Module      : color_range_check
//  Description : Inclusive [lo,hi] window check on all three colour channels
//                of one class. A class whose lo exceeds hi never hits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_range_check
    import color_pkg::*;
#(
    parameter int CH_W = CH_W_DEFAULT
) (
    input  logic [3*CH_W-1:0] i_rgb,
    input  logic [3*CH_W-1:0] i_lo,
    input  logic [3*CH_W-1:0] i_hi,
    output logic              o_hit
);

    logic [2:0] w_ch_hit;

    assign w_ch_hit[CH_R] = (i_rgb[CH_R*CH_W +: CH_W] >= i_lo[CH_R*CH_W +: CH_W]) &&
                            (i_rgb[CH_R*CH_W +: CH_W] <= i_hi[CH_R*CH_W +: CH_W]);
    assign w_ch_hit[CH_G] = (i_rgb[CH_G*CH_W +: CH_W] >= i_lo[CH_G*CH_W +: CH_W]) &&
                            (i_rgb[CH_G*CH_W +: CH_W] <= i_hi[CH_G*CH_W +: CH_W]);
    assign w_ch_hit[CH_B] = (i_rgb[CH_B*CH_W +: CH_W] >= i_lo[CH_B*CH_W +: CH_W]) &&
                            (i_rgb[CH_B*CH_W +: CH_W] <= i_hi[CH_B*CH_W +: CH_W]);

    assign o_hit = &w_ch_hit;

endmodule

`default_nettype wire

// File: rtl/color_classifier.sv
// ============================================================================
//  Module      : color_classifier
//  Description : Streaming RGB classifier. Programmable per-class windows,
//                2-stage valid/ready pipeline, persistence filter producing a
//                stable class. Optional per-class hit statistics are built
//                when COLOR_CLASSIFIER_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_classifier
    import color_pkg::*;
#(
    parameter int CH_W        = CH_W_DEFAULT,
    parameter int NUM_CLASSES = 5,
    parameter int PERSIST     = 4,
    parameter int CLS_W       = $clog2(NUM_CLASSES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [CLS_W-1:0]       cfg_class,
    input  logic [3*CH_W-1:0]      cfg_lo,
    input  logic [3*CH_W-1:0]      cfg_hi,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3*CH_W-1:0]      in_rgb,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CLASSES-1:0] out_match,
    output logic [CLS_W-1:0]       out_class,
    output logic                   stable_valid,
    output logic [CLS_W-1:0]       stable_class
`ifdef COLOR_CLASSIFIER_STATS_EN
    ,
    input  logic [CLS_W-1:0]       stat_sel,
    output logic [15:0]            stat_cnt,
    input  logic                   stat_clr
`endif
);

    localparam logic [CLS_W-1:0] NONE      = CLS_W'(none_idx(NUM_CLASSES));
    localparam logic [7:0]       PERSIST_C = 8'(PERSIST);

    // Threshold storage
    logic [3*CH_W-1:0]      r_lo [NUM_CLASSES];
    logic [3*CH_W-1:0]      r_hi [NUM_CLASSES];

    // Pipeline
    logic [NUM_CLASSES-1:0] w_match;
    logic                   r_s1_valid;
    logic [NUM_CLASSES-1:0] r_s1_match;
    logic [CLS_W-1:0]       w_s1_class;
    logic                   r_s2_valid;
    logic [NUM_CLASSES-1:0] r_s2_match;
    logic [CLS_W-1:0]       r_s2_class;
    logic                   w_adv;
    logic                   w_hs;

    // Persistence filter
    state_t                 r_state, w_state_n;
    logic [CLS_W-1:0]       r_cand, w_cand_n;
    logic [7:0]             r_count, w_count_n;
    logic [CLS_W-1:0]       r_stable_class, w_stable_class_n;
    logic                   r_stable_valid, w_stable_valid_n;
    logic                   w_restart;

    // Stage advance: S2 can take a new beat when empty or being drained
    assign w_adv     = !r_s2_valid || out_ready;
    assign in_ready  = rst_n && (w_adv || !r_s1_valid);
    assign w_hs      = r_s2_valid && out_ready;

    assign out_valid    = r_s2_valid;
    assign out_match    = r_s2_match;
    assign out_class    = r_s2_class;
    assign stable_valid = r_stable_valid;
    assign stable_class = r_stable_class;

    // Threshold write; out-of-range class indices are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_lo[k] <= '1;
                r_hi[k] <= '0;
            end
        end else if (cfg_we && (cfg_class < NONE)) begin
            r_lo[cfg_class] <= cfg_lo;
            r_hi[cfg_class] <= cfg_hi;
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
        color_range_check #(.CH_W(CH_W)) u_chk (
            .i_rgb (in_rgb),
            .i_lo  (r_lo[k]),
            .i_hi  (r_hi[k]),
            .o_hit (w_match[k])
        );
    end

    // Priority encoder: lowest hitting index wins, NONE when nothing hits
    always_comb begin
        w_s1_class = NONE;
        for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
            if (r_s1_match[k]) w_s1_class = CLS_W'(k);
        end
    end

    // S1 captures the hit vector of each accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1_match <= w_match;
        end
    end

    // S2 holds the delivered result until downstream accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_match <= '0;
            r_s2_class <= NONE;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_match <= r_s1_match;
                r_s2_class <= w_s1_class;
            end
        end
    end

    // Persistence filter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cand         <= NONE;
            r_count        <= '0;
            r_stable_class <= NONE;
            r_stable_valid <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_cand         <= w_cand_n;
            r_count        <= w_count_n;
            r_stable_class <= w_stable_class_n;
            r_stable_valid <= w_stable_valid_n;
        end
    end

    // Persistence filter next state; only moves on an output handshake
    always_comb begin
        w_state_n        = r_state;
        w_cand_n         = r_cand;
        w_count_n        = r_count;
        w_stable_class_n = r_stable_class;
        w_stable_valid_n = r_stable_valid;
        w_restart        = 1'b0;
        if (w_hs) begin
            case (r_state)
                IDLE: w_restart = 1'b1;
                TRACK: begin
                    if (r_s2_class == r_cand) begin
                        if (r_count >= PERSIST_C - 8'd1) begin
                            w_count_n        = PERSIST_C;
                            w_stable_class_n = r_cand;
                            w_stable_valid_n = 1'b1;
                            w_state_n        = LOCKED;
                        end else begin
                            w_count_n = r_count + 8'd1;
                        end
                    end else begin
                        w_restart = 1'b1;
                    end
                end
                LOCKED: begin
                    if (r_s2_class != r_stable_class) w_restart = 1'b1;
                end
                default: w_state_n = IDLE;
            endcase
        end
        // A new candidate starts at count 1; with PERSIST of 1 it is confirmed at once
        if (w_restart) begin
            w_cand_n  = r_s2_class;
            w_count_n = 8'd1;
            if (PERSIST == 1) begin
                w_stable_class_n = r_s2_class;
                w_stable_valid_n = 1'b1;
                w_state_n        = LOCKED;
            end else begin
                w_state_n = TRACK;
            end
        end
    end

`ifdef COLOR_CLASSIFIER_STATS_EN
    logic [15:0] r_stat [NUM_CLASSES + 1];

    // Saturating hit counters, one per class plus "none"; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NUM_CLASSES; k++) r_stat[k] <= '0;
        end else if (stat_clr) begin
            for (int k = 0; k <= NUM_CLASSES; k++) r_stat[k] <= '0;
        end else if (w_hs && (r_stat[r_s2_class] != 16'hFFFF)) begin
            r_stat[r_s2_class] <= r_stat[r_s2_class] + 16'd1;
        end
    end

    assign stat_cnt = (stat_sel <= NONE) ? r_stat[stat_sel] : 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_color_classifier.sv
// ============================================================================
//  Module      : tb_color_classifier
//  Description : Directed self-checking bench for color_classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_classifier;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_class;
    logic [23:0] cfg_lo;
    logic [23:0] cfg_hi;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_match;
    logic [2:0]  out_class;
    logic        stable_valid;
    logic [2:0]  stable_class;
`ifdef COLOR_CLASSIFIER_STATS_EN
    logic [2:0]  stat_sel;
    logic [15:0] stat_cnt;
    logic        stat_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int b_vals  [10] = '{15, 25, 35, 45, 5, 25, 15, 45, 35, 5};
    int exp_cls [10] = '{1, 2, 3, 4, 5, 2, 1, 4, 3, 5};

    color_classifier u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_class    (cfg_class),
        .cfg_lo       (cfg_lo),
        .cfg_hi       (cfg_hi),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rgb       (in_rgb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_match    (out_match),
        .out_class    (out_class),
        .stable_valid (stable_valid),
        .stable_class (stable_class)
`ifdef COLOR_CLASSIFIER_STATS_EN
        ,
        .stat_sel     (stat_sel),
        .stat_cnt     (stat_cnt),
        .stat_clr     (stat_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] cls, input logic [23:0] lo, input logic [23:0] hi);
        cfg_we    = 1'b1;
        cfg_class = cls;
        cfg_lo    = lo;
        cfg_hi    = hi;
        tick();
        cfg_we    = 1'b0;
    endtask

    // One pixel through an otherwise empty pipe, ending with its handshake
    task automatic send_and_get(input string tag, input logic [23:0] rgb,
                                input logic [4:0] exp_m, input logic [2:0] exp_c);
        in_valid  = 1'b1;
        in_rgb    = rgb;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        check_val({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_match"}, 32'(out_match), 32'(exp_m));
        check_val({tag, "_class"}, 32'(out_class), 32'(exp_c));
        tick();
    endtask

    function automatic logic [4:0] onehot(input int c);
        logic [4:0] v;
        v = (c >= 5) ? 5'd0 : 5'(1 << c);
        return v;
    endfunction

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, got, cyc;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_class = '0;
        cfg_lo    = '0;
        cfg_hi    = '0;
        in_valid  = 1'b0;
        in_rgb    = '0;
        out_ready = 1'b0;
`ifdef COLOR_CLASSIFIER_STATS_EN
        stat_sel  = '0;
        stat_clr  = 1'b0;
`endif
        tick(); tick(); tick();

        // Reset state
        check_val("rst_out_valid",    32'(out_valid),    32'd0);
        check_val("rst_out_match",    32'(out_match),    32'd0);
        check_val("rst_out_class",    32'(out_class),    32'd5);
        check_val("rst_stable_valid", 32'(stable_valid), 32'd0);
        check_val("rst_stable_class", 32'(stable_class), 32'd5);
        check_val("rst_in_ready",     32'(in_ready),     32'd0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

        // No thresholds written: every pixel is "none"; stable after 4 beats
        for (int i = 0; i < 4; i++) begin
            send_and_get("none", {8'(i * 60), 8'd128, 8'd255}, 5'd0, 3'd5);
            check_val("none_stable_valid", 32'(stable_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        check_val("none_stable_class", 32'(stable_class), 32'd5);

        // Class windows and boundaries
        cfg_write(3'd0, {8'd200, 8'd0, 8'd0}, {8'd255, 8'd50, 8'd50});
        cfg_write(3'd1, 24'h000000, 24'hFFFFFF);
        send_and_get("red",     {8'd220, 8'd10, 8'd10}, 5'b00011, 3'd0);
        send_and_get("bnd_in",  {8'd200, 8'd50, 8'd0},  5'b00011, 3'd0);
        send_and_get("bnd_out", {8'd199, 8'd50, 8'd0},  5'b00010, 3'd1);
        send_and_get("g_over",  {8'd255, 8'd51, 8'd50}, 5'b00010, 3'd1);

        // Burst of 10 with a 5-cycle downstream stall
        cfg_write(3'd1, {8'd0, 8'd0, 8'd10}, {8'd255, 8'd255, 8'd19});
        cfg_write(3'd2, {8'd0, 8'd0, 8'd20}, {8'd255, 8'd255, 8'd29});
        cfg_write(3'd3, {8'd0, 8'd0, 8'd30}, {8'd255, 8'd255, 8'd39});
        cfg_write(3'd4, {8'd0, 8'd0, 8'd40}, {8'd255, 8'd255, 8'd49});
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 10 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (sent < 10);
            in_rgb    = {8'd0, 8'd0, 8'(b_vals[(sent < 10) ? sent : 0])};
            #1;
            if (cyc == 5 || cyc == 7) begin
                check_val("stall_in_ready",  32'(in_ready),  32'd0);
                check_val("stall_out_valid", 32'(out_valid), 32'd1);
                check_val("stall_hold_cls",  32'(out_class), 32'(exp_cls[got]));
            end
            if (out_valid && out_ready) begin
                check_val("burst_class", 32'(out_class), 32'(exp_cls[got]));
                check_val("burst_match", 32'(out_match), 32'(onehot(exp_cls[got])));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("burst_got",  32'(got),  32'd10);
        check_val("burst_sent", 32'(sent), 32'd10);
        tick();
        check_val("burst_no_dup", 32'(out_valid), 32'd0);

        // Reset mid-stream discards the in-flight pixel
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rgb    = {8'd0, 8'd0, 8'd15};
        tick();
        in_valid  = 1'b0;
        tick();
        check_val("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(out_valid),    32'd0);
        check_val("mid_rst_class", 32'(out_class),    32'd5);
        check_val("mid_rst_sv",    32'(stable_valid), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_val("mid_no_ghost", 32'(out_valid), 32'd0);

        // Persistence: 0,0,0,2,0,0,0,0 confirms 0 only on the 8th beat
        cfg_write(3'd0, {8'd200, 8'd0, 8'd0}, {8'd255, 8'd50, 8'd50});
        cfg_write(3'd2, {8'd0, 8'd0, 8'd20}, {8'd255, 8'd255, 8'd29});
        for (int i = 0; i < 8; i++) begin
            if (i == 3) send_and_get("p_c2", {8'd0, 8'd0, 8'd25}, 5'b00100, 3'd2);
            else        send_and_get("p_c0", {8'd220, 8'd10, 8'd10}, 5'b00001, 3'd0);
            check_val("persist_sv", 32'(stable_valid), (i == 7) ? 32'd1 : 32'd0);
        end
        check_val("persist_class", 32'(stable_class), 32'd0);

        // Config written on the same edge a pixel is accepted
        in_valid  = 1'b1;
        in_rgb    = {8'd0, 8'd0, 8'd25};
        out_ready = 1'b1;
        cfg_we    = 1'b1;
        cfg_class = 3'd2;
        cfg_lo    = 24'hFFFFFF;
        cfg_hi    = 24'h000000;
        tick();
        cfg_we    = 1'b0;
        tick();
        in_valid  = 1'b0;
        check_val("cfg_old_valid", 32'(out_valid), 32'd1);
        check_val("cfg_old_class", 32'(out_class), 32'd2);
        tick();
        check_val("cfg_new_valid", 32'(out_valid), 32'd1);
        check_val("cfg_new_class", 32'(out_class), 32'd5);
        check_val("cfg_new_match", 32'(out_match), 32'd0);
        tick();

`ifdef COLOR_CLASSIFIER_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        cfg_write(3'd1, 24'h000000, 24'hFFFFFF);
        for (int i = 0; i < 3; i++) send_and_get("st_c1", 24'h000000, 5'b00010, 3'd1);
        stat_sel = 3'd1;
        #1;
        check_val("stat_c1", 32'(stat_cnt), 32'd3);
        stat_sel = 3'd5;
        #1;
        check_val("stat_none", 32'(stat_cnt), 32'd0);
        stat_sel = 3'd1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check_val("stat_clr", 32'(stat_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
